// File: rtl/linescanner_frame_scheduler_if.sv
// Pixel stream bundle: raw line from the capture unit in, framed pixels out.
interface linescanner_frame_scheduler_if;
  logic       pixel_captured;
  logic [7:0] pixel_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sol;
  logic       out_eol;
  logic       out_sof;
  logic       out_eof;

  // Scheduler side
  modport master (
    input  pixel_captured, pixel_data,
    output out_data, out_valid, out_sol, out_eol, out_sof, out_eof
  );

  // Capture unit / downstream side
  modport slave (
    output pixel_captured, pixel_data,
    input  out_data, out_valid, out_sol, out_eol, out_sof, out_eof
  );
endinterface

// File: rtl/linescanner_frame_scheduler.sv
// Frame sequencer: timed per-line capture trigger, line counting, pixel
// stream framing (SOL/EOL/SOF/EOF) and short/missed/overrun fault pulses.
module linescanner_frame_scheduler #(
  parameter int PIXELS_PER_LINE = 1024,
  parameter int ENABLE_CYCLES   = 1,
  parameter int CNT_W           = 16
) (
  input  logic                 pixel_clock,
  input  logic                 n_reset,
  input  logic                 frame_start,
  input  logic                 frame_abort,
  input  logic [CNT_W-1:0]     cfg_lines,
  input  logic [CNT_W-1:0]     cfg_line_period,
  output logic                 capture_enable,
  linescanner_frame_scheduler_if.master pix,
  output logic [CNT_W-1:0]     line_index,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_aborted,
  output logic                 cfg_error,
  output logic                 short_line,
  output logic                 missed_line,
  output logic                 period_overrun
);

  localparam int PIX_W = $clog2(PIXELS_PER_LINE + 1);
  localparam logic [PIX_W-1:0] PIX_FULL = PIX_W'(PIXELS_PER_LINE);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] EN_CNT   = CNT_W'(ENABLE_CYCLES);
  localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(ENABLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TRIGGER, S_WAIT_LINE, S_LINE, S_GAP, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   lines_q, lines_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]   line_q, line_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               sol_q, sol_d, eol_q, eol_d, sof_q, sof_d, eof_q, eof_d;
  logic               done_q, done_d, aborted_q, aborted_d, cfg_err_q, cfg_err_d;
  logic               short_q, short_d, missed_q, missed_d, overrun_q, overrun_d;
  logic               cap_en, decide, per_last, en_last, last_line;
  logic [CNT_W:0]     line_next;

  // Period counter is zeroed at each trigger, so it reads k clocks after it.
  assign per_last  = per_cnt_q >= (period_q - CNT_W'(1));
  assign en_last   = per_cnt_q == EN_LAST;
  assign line_next = {1'b0, line_q} + {{CNT_W{1'b0}}, 1'b1};
  assign last_line = line_next == {1'b0, lines_q};

  // Next-state, pixel framing and status pulse generation
  always_comb begin
    state_d   = state_q;
    lines_d   = lines_q;
    period_d  = period_q;
    line_d    = line_q;
    pix_d     = pix_q;
    per_cnt_d = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + CNT_W'(1);
    data_d    = data_q;
    valid_d   = 1'b0;
    sol_d     = 1'b0;
    eol_d     = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    cfg_err_d = 1'b0;
    short_d   = 1'b0;
    missed_d  = 1'b0;
    overrun_d = 1'b0;
    cap_en    = 1'b0;
    decide    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          if (cfg_lines != '0 && cfg_line_period > EN_CNT) begin
            lines_d   = cfg_lines;
            period_d  = cfg_line_period;
            line_d    = '0;
            per_cnt_d = '0;
            state_d   = S_TRIGGER;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_TRIGGER: begin
        cap_en = 1'b1;
        pix_d  = '0;
        if (en_last) state_d = S_WAIT_LINE;
      end
      S_WAIT_LINE: begin
        if (pix.pixel_captured) begin
          valid_d = 1'b1;
          data_d  = pix.pixel_data;
          sol_d   = 1'b1;
          sof_d   = (line_q == '0);
          pix_d   = PIX_W'(1);
          state_d = S_LINE;
        end else if (per_last) begin
          missed_d = 1'b1;
          decide   = 1'b1;
        end
      end
      S_LINE: begin
        if (pix.pixel_captured) begin
          // Excess pixels keep the line open but are not emitted.
          if (pix_q < PIX_FULL) begin
            valid_d = 1'b1;
            data_d  = pix.pixel_data;
            pix_d   = pix_q + PIX_W'(1);
            if (pix_q == PIX_LAST) begin
              eol_d = 1'b1;
              eof_d = last_line;
            end
          end
        end else begin
          short_d   = (pix_q < PIX_FULL);
          overrun_d = per_last;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (per_last) decide = 1'b1;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (decide) begin
      if (last_line) begin
        state_d = S_DONE;
      end else begin
        state_d   = S_TRIGGER;
        line_d    = line_next[CNT_W-1:0];
        per_cnt_d = '0;
      end
    end

    // Abort overrides everything decided above in the same cycle.
    if (frame_abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      cap_en    = 1'b0;
      valid_d   = 1'b0;
      sol_d     = 1'b0;
      eol_d     = 1'b0;
      sof_d     = 1'b0;
      eof_d     = 1'b0;
      done_d    = 1'b0;
      short_d   = 1'b0;
      missed_d  = 1'b0;
      overrun_d = 1'b0;
      aborted_d = 1'b1;
    end
  end

  // State, counters and registered outputs with synchronous active-low reset
  always_ff @(posedge pixel_clock) begin
    if (!n_reset) begin
      state_q   <= S_IDLE;
      lines_q   <= '0;
      period_q  <= '0;
      per_cnt_q <= '0;
      line_q    <= '0;
      pix_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sol_q     <= 1'b0;
      eol_q     <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cfg_err_q <= 1'b0;
      short_q   <= 1'b0;
      missed_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lines_q   <= lines_d;
      period_q  <= period_d;
      per_cnt_q <= per_cnt_d;
      line_q    <= line_d;
      pix_q     <= pix_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sol_q     <= sol_d;
      eol_q     <= eol_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      cfg_err_q <= cfg_err_d;
      short_q   <= short_d;
      missed_q  <= missed_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign capture_enable = cap_en;
  assign line_index     = line_q;
  assign frame_done     = done_q;
  assign frame_aborted  = aborted_q;
  assign cfg_error      = cfg_err_q;
  assign short_line     = short_q;
  assign missed_line    = missed_q;
  assign period_overrun = overrun_q;
  assign pix.out_data   = data_q;
  assign pix.out_valid  = valid_q & ~(frame_abort & busy);
  assign pix.out_sol    = sol_q;
  assign pix.out_eol    = eol_q;
  assign pix.out_sof    = sof_q;
  assign pix.out_eof    = eof_q;

endmodule

// File: tb/tb_linescanner_frame_scheduler.sv
// Bench for linescanner_frame_scheduler: a per-frame timeline model predicts
// every output cycle by cycle from trigger times and line windows.
module tb_linescanner_frame_scheduler;
  localparam int PPL  = 8;
  localparam int EN   = 1;
  localparam int W    = 16;
  localparam int MAXC = 2048;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic frame_start = 1'b0;
  logic frame_abort = 1'b0;
  logic [W-1:0] cfg_lines = '0;
  logic [W-1:0] cfg_line_period = '0;
  logic capture_enable;
  logic [W-1:0] line_index;
  logic busy, frame_done, frame_aborted, cfg_error, short_line, missed_line, period_overrun;

  linescanner_frame_scheduler_if pix();

  linescanner_frame_scheduler #(
    .PIXELS_PER_LINE(PPL),
    .ENABLE_CYCLES(EN),
    .CNT_W(W)
  ) dut (
    .pixel_clock(clk),
    .n_reset(n_reset),
    .frame_start(frame_start),
    .frame_abort(frame_abort),
    .cfg_lines(cfg_lines),
    .cfg_line_period(cfg_line_period),
    .capture_enable(capture_enable),
    .pix(pix),
    .line_index(line_index),
    .busy(busy),
    .frame_done(frame_done),
    .frame_aborted(frame_aborted),
    .cfg_error(cfg_error),
    .short_line(short_line),
    .missed_line(missed_line),
    .period_overrun(period_overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Scenario description
  int n_lines, period, abort_at, extra_start_at, last_cyc;
  bit abort_with_start;
  int dly_a[8];
  int len_a[8];

  // Expected timeline, indexed by cycle relative to the frame_start cycle
  bit       d_lval[MAXC];
  bit [7:0] d_data[MAXC];
  bit       e_valid[MAXC], e_sol[MAXC], e_eol[MAXC], e_sof[MAXC], e_eof[MAXC];
  bit [7:0] e_data[MAXC];
  bit       e_cap[MAXC], e_busy[MAXC], e_done[MAXC], e_abt[MAXC];
  bit       e_short[MAXC], e_miss[MAXC], e_ovr[MAXC];
  int       e_lidx[MAXC];

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, c, obs, exp);
    end
  endtask

  function automatic void build();
    int t, d, s, e;
    d = 0;
    for (int c = 0; c < MAXC; c++) begin
      d_lval[c] = 0; d_data[c] = 8'($urandom);
      e_valid[c] = 0; e_sol[c] = 0; e_eol[c] = 0; e_sof[c] = 0; e_eof[c] = 0;
      e_data[c] = 0; e_cap[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_abt[c] = 0;
      e_short[c] = 0; e_miss[c] = 0; e_ovr[c] = 0; e_lidx[c] = 0;
    end
    t = 1;
    for (int k = 0; k < n_lines; k++) begin
      for (int i = 0; i < EN; i++) e_cap[t + i] = 1;
      if (len_a[k] == 0) begin
        d = t + period - 1;
        e_miss[d + 1] = 1;
      end else begin
        s = t + dly_a[k];
        for (int i = 0; i < len_a[k]; i++) begin
          d_lval[s + i] = 1;
          if (i < PPL) begin
            e_valid[s + i + 1] = 1;
            e_data[s + i + 1]  = d_data[s + i];
            e_sol[s + i + 1]   = (i == 0);
            e_sof[s + i + 1]   = (i == 0) && (k == 0);
            e_eol[s + i + 1]   = (i == PPL - 1);
            e_eof[s + i + 1]   = (i == PPL - 1) && (k == n_lines - 1);
          end
        end
        e = s + len_a[k];
        if (len_a[k] < PPL) e_short[e + 1] = 1;
        if (e - t >= period - 1) begin
          e_ovr[e + 1] = 1;
          d = e + 1;
        end else begin
          d = t + period - 1;
        end
      end
      for (int c = t; c <= d; c++) e_lidx[c] = k;
      t = d + 1;
    end
    for (int c = 1; c <= d + 1; c++) e_busy[c] = 1;
    for (int c = d + 1; c < MAXC; c++) e_lidx[c] = n_lines - 1;
    e_done[d + 2] = 1;
    last_cyc = d + 4;
    if (abort_at >= 0) begin
      for (int c = abort_at; c < MAXC; c++) begin
        e_valid[c] = 0; e_cap[c] = 0;
        e_lidx[c] = e_lidx[abort_at];
        if (c > abort_at) begin
          d_lval[c] = 0; e_busy[c] = 0; e_done[c] = 0;
          e_short[c] = 0; e_miss[c] = 0; e_ovr[c] = 0;
        end
      end
      e_abt[abort_at + 1] = 1;
      last_cyc = abort_at + 4;
    end
  endfunction

  task automatic setup(input int lines, input int per);
    n_lines = lines; period = per;
    abort_at = -1; extra_start_at = -1; abort_with_start = 0;
    for (int k = 0; k < 8; k++) begin dly_a[k] = 10; len_a[k] = PPL; end
  endtask

  task automatic run_frame();
    build();
    cfg_lines = W'(n_lines);
    cfg_line_period = W'(period);
    for (int c = 0; c <= last_cyc; c++) begin
      frame_start = (c == 0) || (c == extra_start_at);
      frame_abort = (c == abort_at) || (c == 0 && abort_with_start);
      pix.pixel_captured = d_lval[c];
      pix.pixel_data = d_data[c];
      @(negedge clk);
      chk("capture_enable", c, capture_enable, e_cap[c]);
      chk("busy", c, busy, e_busy[c]);
      chk("out_valid", c, pix.out_valid, e_valid[c]);
      if (e_valid[c]) begin
        chk("out_data", c, pix.out_data, e_data[c]);
        chk("out_sol", c, pix.out_sol, e_sol[c]);
        chk("out_eol", c, pix.out_eol, e_eol[c]);
        chk("out_sof", c, pix.out_sof, e_sof[c]);
        chk("out_eof", c, pix.out_eof, e_eof[c]);
      end
      chk("frame_done", c, frame_done, e_done[c]);
      chk("frame_aborted", c, frame_aborted, e_abt[c]);
      chk("short_line", c, short_line, e_short[c]);
      chk("missed_line", c, missed_line, e_miss[c]);
      chk("period_overrun", c, period_overrun, e_ovr[c]);
      chk("cfg_error", c, cfg_error, 1'b0);
      if (c >= 1) chk("line_index", c, line_index, e_lidx[c]);
      @(posedge clk); #1;
    end
    frame_start = 0; frame_abort = 0; pix.pixel_captured = 0;
  endtask

  task automatic cfg_err_case(input int lines, input int per);
    cfg_lines = W'(lines);
    cfg_line_period = W'(per);
    for (int c = 0; c < 4; c++) begin
      frame_start = (c == 0);
      @(negedge clk);
      chk("cfg_error", c, cfg_error, (c == 1));
      chk("cfg_busy", c, busy, 1'b0);
      chk("cfg_capture_enable", c, capture_enable, 1'b0);
      @(posedge clk); #1;
    end
    frame_start = 0;
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, 0, busy, 1'b0);
    chk({tag, "_capture_enable"}, 0, capture_enable, 1'b0);
    chk({tag, "_out_valid"}, 0, pix.out_valid, 1'b0);
    chk({tag, "_out_data"}, 0, pix.out_data, 8'h00);
    chk({tag, "_line_index"}, 0, line_index, '0);
    chk({tag, "_pulses"}, 0, {frame_done, frame_aborted, cfg_error, short_line,
        missed_line, period_overrun, pix.out_sol, pix.out_eol, pix.out_sof, pix.out_eof}, '0);
  endtask

  initial begin
    pix.pixel_captured = 0;
    pix.pixel_data = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    n_reset = 1;
    @(posedge clk); #1;

    // Nominal 3-line frame, with a frame_start while busy that must be ignored
    setup(3, 40);
    extra_start_at = 30;
    run_frame();

    // Configuration errors
    cfg_err_case(0, 40);
    cfg_err_case(3, 1);

    // Short second line
    setup(3, 40);
    len_a[1] = 5;
    run_frame();

    // Third line never arrives
    setup(3, 40);
    len_a[2] = 0;
    run_frame();

    // Long first line: dropped pixels and period overrun
    setup(2, 40);
    len_a[0] = 60;
    run_frame();

    // Minimum legal period, every line missed
    setup(2, 2);
    len_a[0] = 0; len_a[1] = 0;
    run_frame();

    // Abort in the middle of line 1, coincident with a pixel
    setup(3, 40);
    abort_at = 41 + 10 + 3;
    run_frame();

    // Start together with abort in IDLE: start wins, full frame
    setup(3, 40);
    abort_with_start = 1;
    run_frame();

    // Randomised frames
    for (int r = 0; r < 4; r++) begin
      int lim;
      setup(int'($urandom_range(1, 4)), int'($urandom_range(20, 50)));
      lim = (period - 1 < 12) ? period - 1 : 12;
      for (int k = 0; k < n_lines; k++) begin
        dly_a[k] = int'($urandom_range(EN, lim));
        case ($urandom_range(0, 3))
          0: len_a[k] = 0;
          1: len_a[k] = int'($urandom_range(1, PPL - 1));
          2: len_a[k] = PPL;
          default: len_a[k] = int'($urandom_range(PPL + 1, period + 10));
        endcase
      end
      run_frame();
    end

    // Reset asserted mid-line
    cfg_lines = W'(2);
    cfg_line_period = W'(40);
    for (int c = 0; c < 15; c++) begin
      frame_start = (c == 0);
      pix.pixel_captured = (c >= 11);
      pix.pixel_data = 8'($urandom);
      @(posedge clk); #1;
    end
    frame_start = 0;
    pix.pixel_captured = 0;
    n_reset = 0;
    @(posedge clk); #1;
    check_all_zero("midreset");
    n_reset = 1;
    @(posedge clk); #1;
    check_all_zero("postreset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/linescanner_frame_scheduler.md
# linescanner_frame_scheduler

Frame-level sequencer for the line-scanner capture path. Issues a timed per-line `capture_enable` trigger to the capture unit, counts lines per frame, and frames the returned pixel stream (`pixel_captured`/`pixel_data`) with start/end-of-line and start/end-of-frame markers. Also reports short-line, missed-line and period-overrun faults. Sits between host/DMA control logic and the capture unit, in the `pixel_clock` domain.

## Interface
- `PIXELS_PER_LINE`, 1024: pixels expected per line (≥2).
- `ENABLE_CYCLES`, 1: width of each `capture_enable` pulse in clocks (≥1).
- `CNT_W`, 16: width of line and period counters/config inputs.

- `pixel_clock`  in  1  sole clock, all logic on rising edge.
- `n_reset`  in  1  synchronous, active-low reset.
- `frame_start`  in  1  single-cycle request to acquire one frame; sampled in IDLE only.
- `frame_abort`  in  1  stop the current frame immediately.
- `cfg_lines`  in  CNT_W  lines per frame, latched on accepted `frame_start`.
- `cfg_line_period`  in  CNT_W  clocks between successive line triggers, latched with `cfg_lines`.
- `capture_enable`  out  1  trigger to the capture unit's `enable`.
- `pixel_captured`  in  1  line-valid from the capture unit.
- `pixel_data`  in  8  pixel from the capture unit.
- `out_data`  out  8  registered pixel.
- `out_valid`  out  1  `out_data` qualifier.
- `out_sol`, `out_eol`, `out_sof`, `out_eof`  out  1 each  markers, only meaningful with `out_valid`.
- `line_index`  out  CNT_W  index of the line being emitted (0-based).
- `busy`  out  1  high in every state except IDLE.
- `frame_done`, `frame_aborted`, `cfg_error`, `short_line`, `missed_line`, `period_overrun`  out  1 each  single-cycle status pulses.

## Operation
- Reset: all outputs 0, all counters 0, state IDLE.
- States: IDLE, TRIGGER, WAIT_LINE, LINE, GAP, DONE.
- IDLE:
  - `frame_start` with `cfg_lines`≠0 and `cfg_line_period` > ENABLE_CYCLES: latch config, clear line counter, go to TRIGGER.
  - Otherwise pulse `cfg_error` and stay in IDLE.
- TRIGGER: `capture_enable`=1 for exactly ENABLE_CYCLES clocks; the period counter resets to 0 on the first TRIGGER cycle; then go to WAIT_LINE.
- WAIT_LINE:
  - `pixel_captured`=1: go to LINE; that cycle is pixel 0.
  - Period counter reaches `cfg_line_period`-1 with no line: pulse `missed_line`, count the line as done, go to the GAP decision with no data emitted.
- LINE:
  - Each cycle with `pixel_captured`=1 and pixel count < PIXELS_PER_LINE: emit the pixel and increment the pixel count.
  - Pixels beyond PIXELS_PER_LINE are dropped.
  - Line ends on the PIXELS_PER_LINE-th pixel or when `pixel_captured` falls.
  - If it falls early: pulse `short_line` on the fall cycle; no `out_eol` for that line.
- GAP:
  - Wait until the period counter = `cfg_line_period`-1.
  - If the line ends after the period has already expired: pulse `period_overrun` and make the GAP decision on the next cycle.
  - Decision: lines done = `cfg_lines` → DONE, else → TRIGGER.
- DONE: pulse `frame_done`, return to IDLE.
- Markers:
  - `out_sol` on pixel 0 of every line.
  - `out_sof` on pixel 0 of line 0.
  - `out_eol` on pixel PIXELS_PER_LINE-1.
  - `out_eof` = `out_eol` on the line with index `cfg_lines`-1.
  - `line_index` is held stable across its line.
- `frame_abort` in any non-IDLE state, including simultaneous with a pixel:
  - `capture_enable` and `out_valid` forced 0 in the abort cycle.
  - Next state IDLE; pulse `frame_aborted`; no `frame_done`.
  - Abort in IDLE has no effect.
- `frame_start` while `busy`: ignored. `frame_start` together with `frame_abort` in IDLE: start wins.
- Period counter is CNT_W bits and saturates at its maximum value; it never wraps.

## Timing
- `frame_start` accepted at cycle 0: `busy` and `capture_enable` rise at cycle 1.
- `capture_enable` is high for cycles 1..ENABLE_CYCLES.
- Line triggers occur at cycle 1 + k·`cfg_line_period`, absent overruns.
- Pixel latency: `pixel_captured`/`pixel_data` at edge t → `out_valid`/`out_data` at t+1; markers are aligned with their pixel.
- `frame_done` fires one cycle after the GAP decision of the last line; `busy` falls in the same cycle as `frame_done`.
- Reset asserted mid-frame: outputs 0 on the next edge, no status pulses.

## Test plan
- Nominal frame, PIXELS_PER_LINE=8, cfg_lines=3, period=40, lval high 8 cycles from trigger+10 → 24 `out_valid`, `out_sof`/`out_sol` on pixel 0, `out_eol` ×3, `out_eof` once, triggers at cycles 1/41/81, one `frame_done`.
- cfg_lines=0 or period=1 with `frame_start` → `cfg_error` pulse, `busy` stays 0, no `capture_enable`.
- Line 1 lval only 5 cycles → `short_line` pulse, 5 pixels, no `out_eol`, frame still completes with `frame_done`.
- Lval withheld on line 2 → `missed_line` at period expiry, line counted, next trigger on schedule.
- Lval 60 cycles long with period=40 → pixels 8+ dropped, `period_overrun` pulse, next trigger immediately after line end.
- `frame_abort` mid-line 1 → `out_valid` 0 that cycle, `frame_aborted` pulse, IDLE, no `frame_done`; new `frame_start` then runs a full frame.
